// File: rtl/instr_streamer.sv
// Automatic program source for the 10-bit processor: plays a loaded program onto PDATA,
// pulses STEP in place of the operator's button and follows PDONE from one instruction to the next.
module instr_streamer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned STEP_GAP  = 4,
    parameter int unsigned MAX_STEPS = 8,
    parameter logic [3:0]  MVI_OP    = 4'b0010,
    parameter logic [9:0]  END_WORD  = 10'h3FF
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          LOADEN,
    input  logic [AW-1:0] LOADADDR,
    input  logic [9:0]    LOADDATA,
    input  logic          START,
    input  logic          HALT,
    input  logic          PDONE,
    output logic [9:0]    PDATA,
    output logic          STEP,
    output logic [AW-1:0] PC,
    output logic          BUSY,
    output logic          FINISHED,
    output logic          FAULT
);

    localparam int unsigned NW = $clog2(MAX_STEPS + 1);
    localparam int unsigned GW = (STEP_GAP > 2) ? $clog2(STEP_GAP - 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_ISSUE, S_FIN, S_FAULT
    } state_t;

    state_t        state, state_n;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    cur_word, imm_word, pdata_n;
    logic [AW-1:0] pc_inc, pc_n;
    logic [NW-1:0] nsteps, nsteps_n, nsteps_inc;
    logic [GW-1:0] gap_cnt, gap_cnt_n;
    logic          imm, imm_n, finished_n, fault_n;
    logic          start_go, pc_last, imm_hit;

    assign cur_word   = mem[PC];
    assign pc_inc     = PC + 1'b1;
    assign imm_word   = mem[pc_inc];
    assign nsteps_inc = nsteps + 1'b1;
    assign pc_last    = (PC == AW'(DEPTH - 1));
    assign imm_hit    = imm && (nsteps_inc == NW'(1));
    assign start_go   = (state == S_IDLE || state == S_FIN || state == S_FAULT) && START && !HALT;

    always_ff @(posedge CLK) begin
        if (!CLR && LOADEN && !BUSY)
            mem[LOADADDR] <= LOADDATA;
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= S_IDLE;
            PC       <= '0;
            PDATA    <= '0;
            STEP     <= 1'b0;
            BUSY     <= 1'b0;
            FINISHED <= 1'b0;
            FAULT    <= 1'b0;
            nsteps   <= '0;
            imm      <= 1'b0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            PC       <= pc_n;
            PDATA    <= pdata_n;
            STEP     <= (state_n == S_ISSUE);
            BUSY     <= (state_n == S_FETCH) || (state_n == S_SETUP) || (state_n == S_ISSUE);
            FINISHED <= finished_n;
            FAULT    <= fault_n;
            nsteps   <= nsteps_n;
            imm      <= imm_n;
            gap_cnt  <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_FIN, S_FAULT: if (start_go) state_n = S_FETCH;
            S_FETCH: begin
                if (HALT)                       state_n = S_IDLE;
                else if (cur_word == END_WORD)  state_n = S_FIN;
                else                            state_n = S_SETUP;
            end
            S_SETUP: begin
                if (HALT)                                state_n = S_IDLE;
                else if (gap_cnt == GW'(STEP_GAP - 2))   state_n = S_ISSUE;
            end
            S_ISSUE: begin
                // PDONE outranks the immediate fetch, which outranks the step limit
                if (HALT)                                  state_n = S_IDLE;
                else if (PDONE)                            state_n = pc_last ? S_FIN : S_FETCH;
                else if (imm_hit)                          state_n = pc_last ? S_FAULT : S_SETUP;
                else if (nsteps_inc == NW'(MAX_STEPS))     state_n = S_FAULT;
                else                                       state_n = S_SETUP;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pc_n       = PC;
        pdata_n    = PDATA;
        nsteps_n   = nsteps;
        imm_n      = imm;
        gap_cnt_n  = '0;
        finished_n = FINISHED;
        fault_n    = FAULT;
        if (start_go) begin
            pc_n       = '0;
            nsteps_n   = '0;
            imm_n      = 1'b0;
            finished_n = 1'b0;
            fault_n    = 1'b0;
        end
        if (!HALT) begin
            unique case (state)
                S_FETCH: begin
                    if (cur_word != END_WORD) begin
                        pdata_n  = cur_word;
                        nsteps_n = '0;
                        imm_n    = (cur_word[9:6] == MVI_OP);
                    end
                end
                S_SETUP: gap_cnt_n = gap_cnt + 1'b1;
                S_ISSUE: begin
                    nsteps_n = nsteps_inc;
                    if (PDONE) begin
                        if (!pc_last) pc_n = pc_inc;
                    end else if (imm_hit && !pc_last) begin
                        pc_n    = pc_inc;
                        pdata_n = imm_word;
                        imm_n   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        if (state_n == S_FIN)   finished_n = 1'b1;
        if (state_n == S_FAULT) fault_n    = 1'b1;
    end

endmodule

// File: tb/tb_instr_streamer.sv
// Directed bench for instr_streamer: a small PDONE model answers STEP pulses and logs
// every presented word; each step of the sequence checks against hand-computed values.
module tb_instr_streamer;

    logic       CLK = 1'b0;
    logic       CLR, LOADEN, START, HALT;
    logic       PDONE = 1'b0;
    logic [3:0] LOADADDR;
    logic [9:0] LOADDATA;
    logic [9:0] PDATA;
    logic       STEP, BUSY, FINISHED, FAULT;
    logic [3:0] PC;

    int checks = 0;
    int errors = 0;

    // PDONE model: 0 never, 1 on every step while steps_run <= pd_limit, 2 on the pd_nth step of an instruction
    int pd_mode = 0, pd_nth = 0, pd_limit = 0;
    int steps_run = 0, steps_instr = 0, cyc = 0;
    logic [9:0] log_pdata[$];
    int         log_cyc[$];

    instr_streamer #(
        .DEPTH(16), .AW(4), .STEP_GAP(4), .MAX_STEPS(8),
        .MVI_OP(4'b0010), .END_WORD(10'h3FF)
    ) dut (
        .CLK(CLK), .CLR(CLR), .LOADEN(LOADEN), .LOADADDR(LOADADDR), .LOADDATA(LOADDATA),
        .START(START), .HALT(HALT), .PDONE(PDONE), .PDATA(PDATA), .STEP(STEP), .PC(PC),
        .BUSY(BUSY), .FINISHED(FINISHED), .FAULT(FAULT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        cyc++;
        PDONE = 1'b0;
        if (!BUSY && !STEP) begin
            steps_run   = 0;
            steps_instr = 0;
        end
        if (STEP) begin
            steps_run++;
            steps_instr++;
            log_pdata.push_back(PDATA);
            log_cyc.push_back(cyc);
            if (pd_mode == 1)      PDONE = (steps_run <= pd_limit);
            else if (pd_mode == 2) PDONE = (steps_instr == pd_nth);
            if (PDONE) steps_instr = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [9:0] d);
        LOADADDR = a;
        LOADDATA = d;
        LOADEN   = 1'b1;
        tick();
        LOADEN   = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic run_wait(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 500) begin
            tick();
            n++;
        end
        chk(tag, BUSY, 1'b0);
    endtask

    initial begin
        int i0, n;
        CLR = 1'b1; LOADEN = 1'b0; START = 1'b0; HALT = 1'b0;
        LOADADDR = '0; LOADDATA = '0;
        repeat (3) tick();
        chk("rst_pdata", PDATA, 10'h000);
        chk("rst_step", STEP, 1'b0);
        chk("rst_pc", PC, 4'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_finished", FINISHED, 1'b0);
        chk("rst_fault", FAULT, 1'b0);
        CLR = 1'b0;
        tick();

        // single instruction completing on its third step
        load(4'd0, 10'h0C5);
        load(4'd1, 10'h3FF);
        pd_mode = 2; pd_nth = 3;
        i0 = log_pdata.size();
        pulse_start();
        chk("t1_busy_after_start", BUSY, 1'b1);
        run_wait("t1_done");
        chk("t1_nsteps", log_pdata.size() - i0, 3);
        for (int k = 0; k < 3; k++) chk("t1_pdata", log_pdata[i0 + k], 10'h0C5);
        chk("t1_gap_a", log_cyc[i0 + 1] - log_cyc[i0], 4);
        chk("t1_gap_b", log_cyc[i0 + 2] - log_cyc[i0 + 1], 4);
        chk("t1_finished", FINISHED, 1'b1);
        chk("t1_fault", FAULT, 1'b0);
        chk("t1_pc", PC, 4'd1);
        chk("t1_step_low", STEP, 1'b0);

        // MVI instruction presents its immediate word on the second step
        load(4'd0, 10'h085);
        load(4'd1, 10'h155);
        load(4'd2, 10'h3FF);
        pd_mode = 2; pd_nth = 2;
        i0 = log_pdata.size();
        pulse_start();
        chk("t2_finished_cleared", FINISHED, 1'b0);
        run_wait("t2_done");
        chk("t2_nsteps", log_pdata.size() - i0, 2);
        chk("t2_step1_pdata", log_pdata[i0], 10'h085);
        chk("t2_step2_pdata", log_pdata[i0 + 1], 10'h155);
        chk("t2_finished", FINISHED, 1'b1);
        chk("t2_pc", PC, 4'd2);

        // processor never signals done: step limit trips FAULT
        load(4'd0, 10'h0C5);
        pd_mode = 0;
        i0 = log_pdata.size();
        pulse_start();
        run_wait("t3_done");
        chk("t3_nsteps", log_pdata.size() - i0, 8);
        chk("t3_fault", FAULT, 1'b1);
        chk("t3_finished", FINISHED, 1'b0);
        chk("t3_pc", PC, 4'd0);
        repeat (10) tick();
        chk("t3_no_more_steps", log_pdata.size() - i0, 8);

        // HALT in the second SETUP stretch, then a clean rerun
        load(4'd1, 10'h3FF);
        pd_mode = 2; pd_nth = 3;
        i0 = log_pdata.size();
        pulse_start();
        chk("t4_fault_cleared", FAULT, 1'b0);
        n = 0;
        while (log_pdata.size() == i0 && n < 100) begin
            tick();
            n++;
        end
        chk("t4_first_step_seen", log_pdata.size() - i0, 1);
        HALT = 1'b1;
        tick();
        HALT = 1'b0;
        chk("t4_halt_busy", BUSY, 1'b0);
        chk("t4_halt_step", STEP, 1'b0);
        chk("t4_halt_pc", PC, 4'd0);
        chk("t4_halt_pdata", PDATA, 10'h0C5);
        repeat (8) tick();
        chk("t4_no_step_after_halt", log_pdata.size() - i0, 1);
        START = 1'b1; HALT = 1'b1;
        tick();
        START = 1'b0; HALT = 1'b0;
        tick();
        chk("t4_halt_beats_start", BUSY, 1'b0);
        i0 = log_pdata.size();
        pulse_start();
        run_wait("t4_rerun_done");
        chk("t4_rerun_nsteps", log_pdata.size() - i0, 3);
        chk("t4_rerun_finished", FINISHED, 1'b1);
        chk("t4_rerun_pc", PC, 4'd1);

        // load attempt while busy, then CLR in the ISSUE cycle
        pd_mode = 0;
        pulse_start();
        load(4'd0, 10'h3FF);
        n = 0;
        @(negedge CLK);
        while (!STEP && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("t5_in_issue", STEP, 1'b1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        chk("t5_clr_pdata", PDATA, 10'h000);
        chk("t5_clr_step", STEP, 1'b0);
        chk("t5_clr_pc", PC, 4'd0);
        chk("t5_clr_busy", BUSY, 1'b0);
        chk("t5_clr_finished", FINISHED, 1'b0);
        chk("t5_clr_fault", FAULT, 1'b0);
        pd_mode = 2; pd_nth = 3;
        i0 = log_pdata.size();
        pulse_start();
        run_wait("t5_rerun_done");
        chk("t5_nsteps", log_pdata.size() - i0, 3);
        chk("t5_old_m0", log_pdata[i0], 10'h0C5);
        chk("t5_finished", FINISHED, 1'b1);

        // full memory without a terminator, then an MVI word in the last slot
        for (int k = 0; k < 16; k++) load(4'(k), 10'h0C0 + 10'(k));
        pd_mode = 1; pd_limit = 16;
        i0 = log_pdata.size();
        pulse_start();
        run_wait("t6_done");
        chk("t6_nsteps", log_pdata.size() - i0, 16);
        for (int k = 0; k < 16; k++) chk("t6_pdata", log_pdata[i0 + k], 10'h0C0 + 10'(k));
        chk("t6_finished", FINISHED, 1'b1);
        chk("t6_fault", FAULT, 1'b0);
        chk("t6_pc", PC, 4'd15);
        load(4'd15, 10'h08F);
        pd_limit = 15;
        i0 = log_pdata.size();
        pulse_start();
        run_wait("t6_mvi_done");
        chk("t6_mvi_nsteps", log_pdata.size() - i0, 16);
        chk("t6_mvi_last_pdata", log_pdata[i0 + 15], 10'h08F);
        chk("t6_mvi_fault", FAULT, 1'b1);
        chk("t6_mvi_finished", FINISHED, 1'b0);
        chk("t6_mvi_pc", PC, 4'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
